// File: rtl/data_mem_resp_pkg.sv
// Shared encodings and request-decode helpers for the data-memory responder.
package data_mem_resp_pkg;

  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'b00,
    CTRL_LOAD  = 2'b01,
    CTRL_STORE = 2'b10,
    CTRL_NOP   = 2'b11
  } ctrl_e;

  typedef enum logic [1:0] {
    TYPE_BYTE     = 2'b00,
    TYPE_HALF     = 2'b01,
    TYPE_WORD     = 2'b10,
    TYPE_WORD_ALT = 2'b11
  } size_e;

  typedef enum logic [3:0] {
    AMO_LR   = 4'd0,
    AMO_SC   = 4'd1,
    AMO_SWAP = 4'd2,
    AMO_ADD  = 4'd3,
    AMO_XOR  = 4'd4,
    AMO_AND  = 4'd5,
    AMO_OR   = 4'd6,
    AMO_MIN  = 4'd7,
    AMO_MAX  = 4'd8,
    AMO_MINU = 4'd9,
    AMO_MAXU = 4'd10
  } amo_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESP,
    ST_AMO_RD,
    ST_AMO_WR
  } state_e;

  localparam int unsigned AMO_REQ_BIT = 4;

  function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
    case (size)
      TYPE_HALF:               return lo[0];
      TYPE_WORD, TYPE_WORD_ALT: return |lo;
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_mask(input size_e size, input logic [1:0] lo);
    case (size)
      TYPE_BYTE: return 4'b0001 << lo;
      TYPE_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input size_e size, input logic [31:0] d);
    case (size)
      TYPE_BYTE: return {4{d[7:0]}};
      TYPE_HALF: return {2{d[15:0]}};
      default:   return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input size_e size, input logic [1:0] lo,
                                               input logic uns, input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {lo, 3'b000};
    case (size)
      TYPE_BYTE: return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      TYPE_HALF: return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default:   return word;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_amo_alu.sv
// Combinational AMO datapath: new memory word from the old word and the rs2 operand.
module amo_alu
  import data_mem_resp_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [31:0] i_operand,
  input  logic [3:0]  i_op,
  output logic [31:0] o_new
);

  always_comb begin
    o_new = i_operand;
    case (i_op)
      AMO_ADD:  o_new = i_old + i_operand;
      AMO_XOR:  o_new = i_old ^ i_operand;
      AMO_AND:  o_new = i_old & i_operand;
      AMO_OR:   o_new = i_old | i_operand;
      AMO_MIN:  o_new = ($signed(i_old) < $signed(i_operand)) ? i_old : i_operand;
      AMO_MAX:  o_new = ($signed(i_old) > $signed(i_operand)) ? i_old : i_operand;
      AMO_MINU: o_new = (i_old < i_operand) ? i_old : i_operand;
      AMO_MAXU: o_new = (i_old > i_operand) ? i_old : i_operand;
      default:  o_new = i_operand;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Tightly-coupled data RAM responder for the execute stage: loads, stores, LR/SC
// with a single reservation, and read-modify-write AMOs.
module data_mem_responder
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [1:0]  DATA_CACHE_CONTROL,
  input  logic [4:0]  AMO_OP,
  input  logic [31:0] DATA_ADDRESS,
  input  logic [1:0]  TYPE_IN,
  input  logic        LOAD_UNSIGNED,
  input  logic [31:0] WDATA,
  output logic        CACHE_READY,
  output logic [31:0] RDATA,
  output logic        RDATA_VALID,
  output logic        MISALIGNED
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_ready;
  logic [31:0]           r_rdata;
  logic                  r_rdata_valid;
  logic                  r_misaligned;
  logic                  r_resv_valid;
  logic [ADDR_WIDTH-1:0] r_resv_addr;
  logic [ADDR_WIDTH-1:0] r_amo_idx;
  logic [31:0]           r_amo_operand;
  logic [3:0]            r_amo_op;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_is_amo;
  logic                  w_is_load;
  logic                  w_req;
  logic                  w_accept;
  logic                  w_is_lr;
  logic                  w_is_sc;
  logic                  w_is_rmw;
  logic                  w_misaligned;
  size_e                 w_size;
  logic [1:0]            w_byte_off;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_unused_addr;

  logic                  w_ram_we;
  logic [3:0]            w_ram_be;
  logic [31:0]           w_ram_wdata;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [31:0]           w_ram_rdata;
  logic [31:0]           w_alu_new;
  logic [31:0]           w_rdata_d;
  logic                  w_rdata_valid_d;
  logic                  w_misaligned_d;
  logic                  w_resv_valid_d;
  logic [ADDR_WIDTH-1:0] w_resv_addr_d;
  logic                  w_amo_latch;

  assign w_is_amo      = AMO_OP[AMO_REQ_BIT];
  assign w_is_load     = !w_is_amo && (DATA_CACHE_CONTROL == CTRL_LOAD);
  assign w_req         = w_is_amo || (DATA_CACHE_CONTROL == CTRL_LOAD)
                                  || (DATA_CACHE_CONTROL == CTRL_STORE);
  assign w_accept      = (r_state == ST_IDLE) && w_req;
  assign w_is_lr       = w_is_amo && (AMO_OP[3:0] == AMO_LR);
  assign w_is_sc       = w_is_amo && (AMO_OP[3:0] == AMO_SC);
  assign w_is_rmw      = w_is_amo && !w_is_lr && !w_is_sc;
  assign w_size        = w_is_amo ? TYPE_WORD : size_e'(TYPE_IN);
  assign w_byte_off    = DATA_ADDRESS[1:0];
  assign w_misaligned  = is_misaligned(w_size, w_byte_off);
  assign w_idx         = DATA_ADDRESS[ADDR_WIDTH+1:2];
  assign w_unused_addr = ^DATA_ADDRESS[31:ADDR_WIDTH+2];

  assign w_ram_rdata = r_mem[w_ram_addr];

  // During AMO_WR the old word sits in r_rdata, so it feeds the ALU directly.
  amo_alu u_amo_alu (
    .i_old     (r_rdata),
    .i_operand (r_amo_operand),
    .i_op      (r_amo_op),
    .o_new     (w_alu_new)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = (w_is_rmw && !w_misaligned) ? ST_AMO_RD : ST_RESP;
      end
      ST_RESP:   w_state_nxt = ST_IDLE;
      ST_AMO_RD: w_state_nxt = ST_AMO_WR;
      ST_AMO_WR: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ram_we        = 1'b0;
    w_ram_be        = '0;
    w_ram_wdata     = '0;
    w_ram_addr      = r_amo_idx;
    w_rdata_d       = r_rdata;
    w_rdata_valid_d = 1'b0;
    w_misaligned_d  = 1'b0;
    w_resv_valid_d  = r_resv_valid;
    w_resv_addr_d   = r_resv_addr;
    w_amo_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ram_addr = w_idx;
        if (w_accept) begin
          if (w_misaligned) begin
            w_misaligned_d  = 1'b1;
            w_rdata_valid_d = 1'b1;
            w_rdata_d       = '0;
          end else if (w_is_rmw) begin
            w_amo_latch = 1'b1;
          end else if (w_is_lr) begin
            w_rdata_d       = w_ram_rdata;
            w_rdata_valid_d = 1'b1;
            w_resv_valid_d  = 1'b1;
            w_resv_addr_d   = w_idx;
          end else if (w_is_sc) begin
            w_rdata_valid_d = 1'b1;
            w_resv_valid_d  = 1'b0;
            if (r_resv_valid && (r_resv_addr == w_idx)) begin
              w_ram_we    = 1'b1;
              w_ram_be    = '1;
              w_ram_wdata = WDATA;
              w_rdata_d   = '0;
            end else begin
              w_rdata_d = 32'd1;
            end
          end else if (w_is_load) begin
            w_rdata_d       = load_extract(w_size, w_byte_off, LOAD_UNSIGNED, w_ram_rdata);
            w_rdata_valid_d = 1'b1;
          end else begin
            w_ram_we    = 1'b1;
            w_ram_be    = store_mask(w_size, w_byte_off);
            w_ram_wdata = store_data(w_size, WDATA);
            if (r_resv_valid && (r_resv_addr == w_idx)) w_resv_valid_d = 1'b0;
          end
        end
      end
      ST_AMO_RD: begin
        w_rdata_d       = w_ram_rdata;
        w_rdata_valid_d = 1'b1;
      end
      ST_AMO_WR: begin
        w_ram_we    = 1'b1;
        w_ram_be    = '1;
        w_ram_wdata = w_alu_new;
        if (r_resv_valid && (r_resv_addr == r_amo_idx)) w_resv_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ready       <= 1'b1;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_misaligned  <= 1'b0;
      r_resv_valid  <= 1'b0;
      r_resv_addr   <= '0;
      r_amo_idx     <= '0;
      r_amo_operand <= '0;
      r_amo_op      <= '0;
    end else begin
      r_ready       <= (w_state_nxt == ST_IDLE);
      r_rdata       <= w_rdata_d;
      r_rdata_valid <= w_rdata_valid_d;
      r_misaligned  <= w_misaligned_d;
      r_resv_valid  <= w_resv_valid_d;
      r_resv_addr   <= w_resv_addr_d;
      if (w_amo_latch) begin
        r_amo_idx     <= w_idx;
        r_amo_operand <= WDATA;
        r_amo_op      <= AMO_OP[3:0];
      end
    end
  end

  // Writes are also gated by RST_N so nothing lands while reset is held.
  always_ff @(posedge CLK) begin
    if (w_ram_we && RST_N) begin
      if (w_ram_be[0]) r_mem[w_ram_addr][7:0]   <= w_ram_wdata[7:0];
      if (w_ram_be[1]) r_mem[w_ram_addr][15:8]  <= w_ram_wdata[15:8];
      if (w_ram_be[2]) r_mem[w_ram_addr][23:16] <= w_ram_wdata[23:16];
      if (w_ram_be[3]) r_mem[w_ram_addr][31:24] <= w_ram_wdata[31:24];
    end
  end

  assign CACHE_READY = r_ready;
  assign RDATA       = r_rdata;
  assign RDATA_VALID = r_rdata_valid;
  assign MISALIGNED  = r_misaligned;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, hand sequences, randomized ops vs model.
module tb_data_mem_responder;

  logic        CLK;
  logic        RST_N;
  logic [1:0]  DATA_CACHE_CONTROL;
  logic [4:0]  AMO_OP;
  logic [31:0] DATA_ADDRESS;
  logic [1:0]  TYPE_IN;
  logic        LOAD_UNSIGNED;
  logic [31:0] WDATA;
  logic        CACHE_READY;
  logic [31:0] RDATA;
  logic        RDATA_VALID;
  logic        MISALIGNED;

  data_mem_responder #(.ADDR_WIDTH(12)) dut (
    .CLK                (CLK),
    .RST_N              (RST_N),
    .DATA_CACHE_CONTROL (DATA_CACHE_CONTROL),
    .AMO_OP             (AMO_OP),
    .DATA_ADDRESS       (DATA_ADDRESS),
    .TYPE_IN            (TYPE_IN),
    .LOAD_UNSIGNED      (LOAD_UNSIGNED),
    .WDATA              (WDATA),
    .CACHE_READY        (CACHE_READY),
    .RDATA              (RDATA),
    .RDATA_VALID        (RDATA_VALID),
    .MISALIGNED         (MISALIGNED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  ctrl;
    logic [4:0]  amo;
    logic [31:0] addr;
    logic [1:0]  typ;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_valid;
    logic        exp_mis;
    int          exp_busy;
  } vec_t;

  localparam logic [1:0] LD = 2'b01, STR = 2'b10, NO = 2'b00;
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10;
  localparam logic [4:0] A_NONE = 5'h00, A_LR = 5'h10, A_SC = 5'h11, A_ADD = 5'h13;
  localparam logic [4:0] A_MIN = 5'h17, A_MINU = 5'h19, A_SWAP12 = 5'h1C;

  int total = 0;
  int bad   = 0;

  // Reference state: memory words, reservation flag and reserved word index.
  logic [31:0] m_mem [4096];
  logic        m_rv = 1'b0;
  int unsigned m_ra = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] c, input logic [4:0] a, input logic [31:0] ad,
                              input logic [1:0] t, input logic u, input logic [31:0] wd,
                              input logic [31:0] er, input int ev, input logic em, input int eb);
    vec_t v;
    v.ctrl = c; v.amo = a; v.addr = ad; v.typ = t; v.uns = u; v.wdata = wd;
    v.exp_rdata = er; v.exp_valid = ev; v.exp_mis = em; v.exp_busy = eb;
    return v;
  endfunction

  // Byte-level model of one accepted request; updates the reference state.
  function automatic vec_t model(input vec_t v);
    vec_t e;
    int nb, o;
    int unsigned idx;
    logic [31:0] old, nw, msk, val;
    e = v;
    idx = (v.addr >> 2) % 4096;
    o = int'(v.addr[1:0]);
    if (v.amo[4]) nb = 4;
    else if (v.typ == 2'b00) nb = 1;
    else if (v.typ == 2'b01) nb = 2;
    else nb = 4;
    e.exp_valid = 1; e.exp_mis = 1'b0; e.exp_busy = 1; e.exp_rdata = 32'h0;
    if (o % nb != 0) begin
      e.exp_mis = 1'b1;
      return e;
    end
    old = m_mem[idx];
    if (v.amo[4]) begin
      if (v.amo[3:0] == 4'd0) begin
        e.exp_rdata = old; m_rv = 1'b1; m_ra = idx;
      end else if (v.amo[3:0] == 4'd1) begin
        if (m_rv && m_ra == idx) begin
          m_mem[idx] = v.wdata; e.exp_rdata = 32'h0;
        end else e.exp_rdata = 32'h1;
        m_rv = 1'b0;
      end else begin
        case (v.amo[3:0])
          4'd3:    nw = old + v.wdata;
          4'd4:    nw = old ^ v.wdata;
          4'd5:    nw = old & v.wdata;
          4'd6:    nw = old | v.wdata;
          4'd7:    nw = ($signed(old) < $signed(v.wdata)) ? old : v.wdata;
          4'd8:    nw = ($signed(old) > $signed(v.wdata)) ? old : v.wdata;
          4'd9:    nw = (old < v.wdata) ? old : v.wdata;
          4'd10:   nw = (old > v.wdata) ? old : v.wdata;
          default: nw = v.wdata;
        endcase
        m_mem[idx] = nw;
        if (m_ra == idx) m_rv = 1'b0;
        e.exp_rdata = old; e.exp_busy = 2;
      end
    end else if (v.ctrl == LD) begin
      msk = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      val = (old >> (8 * o)) & msk;
      if (!v.uns && nb < 4 && (((val >> (8 * nb - 1)) & 32'd1) != 0)) val = val | ~msk;
      e.exp_rdata = val;
    end else begin
      nw = old;
      for (int b = 0; b < nb; b++) nw[8 * (o + b) +: 8] = v.wdata[8 * b +: 8];
      m_mem[idx] = nw;
      if (m_rv && m_ra == idx) m_rv = 1'b0;
      e.exp_valid = 0;
    end
    return e;
  endfunction

  task automatic drive_idle();
    DATA_CACHE_CONTROL = NO; AMO_OP = A_NONE; DATA_ADDRESS = '0;
    TYPE_IN = W; LOAD_UNSIGNED = 1'b0; WDATA = '0;
  endtask

  task automatic drive(input vec_t v);
    DATA_CACHE_CONTROL = v.ctrl; AMO_OP = v.amo; DATA_ADDRESS = v.addr;
    TYPE_IN = v.typ; LOAD_UNSIGNED = v.uns; WDATA = v.wdata;
  endtask

  task automatic run(input vec_t v, input string tag);
    logic [31:0] rd;
    logic mis;
    int vc, vp, busy, guard;
    guard = 0;
    @(negedge CLK);
    while (!CACHE_READY && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    chk({tag, " ready_before"}, CACHE_READY, 1'b1);
    drive(v);
    @(posedge CLK);
    #1 drive_idle();
    rd = '0; mis = 1'b0; vc = 0; vp = 0; busy = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (MISALIGNED) mis = 1'b1;
      if (RDATA_VALID) begin
        vc++; vp = k; rd = RDATA;
      end
      if (CACHE_READY) break;
      busy++;
    end
    chk({tag, " busy_cycles"}, busy, v.exp_busy);
    chk({tag, " valid_pulses"}, vc, v.exp_valid);
    chk({tag, " misaligned"}, {31'h0, mis}, {31'h0, v.exp_mis});
    if (v.exp_valid != 0) begin
      chk({tag, " rdata"}, rd, v.exp_rdata);
      chk({tag, " valid_cycle"}, vp, v.exp_busy);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    vec_t v;
    int k;

    RST_N = 1'b0;
    drive_idle();
    repeat (2) @(negedge CLK);
    chk("reset CACHE_READY", {31'h0, CACHE_READY}, 32'h1);
    chk("reset RDATA", RDATA, 32'h0);
    chk("reset RDATA_VALID", {31'h0, RDATA_VALID}, 32'h0);
    chk("reset MISALIGNED", {31'h0, MISALIGNED}, 32'h0);
    RST_N = 1'b1;

    vecs.push_back(mk(STR, A_NONE, 32'h10, W, 1'b0, 32'hDEADBEEF, 32'h0,        0, 1'b0, 1));
    vecs.push_back(mk(LD,  A_NONE, 32'h13, B, 1'b0, 32'h0,        32'hFFFFFFDE, 1, 1'b0, 1));
    vecs.push_back(mk(LD,  A_NONE, 32'h13, B, 1'b1, 32'h0,        32'h000000DE, 1, 1'b0, 1));
    vecs.push_back(mk(LD,  A_NONE, 32'h12, H, 1'b0, 32'h0,        32'hFFFFDEAD, 1, 1'b0, 1));
    vecs.push_back(mk(LD,  A_NONE, 32'h10, W, 1'b0, 32'h0,        32'hDEADBEEF, 1, 1'b0, 1));
    vecs.push_back(mk(STR, A_NONE, 32'h20, W, 1'b0, 32'h5,        32'h0,        0, 1'b0, 1));
    vecs.push_back(mk(NO,  A_ADD,  32'h20, B, 1'b0, 32'hFFFFFFFE, 32'h5,        1, 1'b0, 2));
    vecs.push_back(mk(LD,  A_NONE, 32'h20, W, 1'b0, 32'h0,        32'h3,        1, 1'b0, 1));
    vecs.push_back(mk(STR, A_NONE, 32'h30, W, 1'b0, 32'h80000000, 32'h0,        0, 1'b0, 1));
    vecs.push_back(mk(NO,  A_MIN,  32'h30, W, 1'b0, 32'h1,        32'h80000000, 1, 1'b0, 2));
    vecs.push_back(mk(LD,  A_NONE, 32'h30, W, 1'b0, 32'h0,        32'h80000000, 1, 1'b0, 1));
    vecs.push_back(mk(NO,  A_MINU, 32'h30, W, 1'b0, 32'h1,        32'h80000000, 1, 1'b0, 2));
    vecs.push_back(mk(LD,  A_NONE, 32'h30, W, 1'b0, 32'h0,        32'h1,        1, 1'b0, 1));
    vecs.push_back(mk(STR, A_NONE, 32'h40, W, 1'b0, 32'h11111111, 32'h0,        0, 1'b0, 1));
    vecs.push_back(mk(NO,  A_LR,   32'h40, W, 1'b0, 32'h0,        32'h11111111, 1, 1'b0, 1));
    vecs.push_back(mk(NO,  A_SC,   32'h40, W, 1'b0, 32'hCAFEF00D, 32'h0,        1, 1'b0, 1));
    vecs.push_back(mk(LD,  A_NONE, 32'h40, W, 1'b0, 32'h0,        32'hCAFEF00D, 1, 1'b0, 1));
    vecs.push_back(mk(NO,  A_SC,   32'h40, W, 1'b0, 32'h12345678, 32'h1,        1, 1'b0, 1));
    vecs.push_back(mk(LD,  A_NONE, 32'h40, W, 1'b0, 32'h0,        32'hCAFEF00D, 1, 1'b0, 1));
    vecs.push_back(mk(NO,  A_LR,   32'h40, W, 1'b0, 32'h0,        32'hCAFEF00D, 1, 1'b0, 1));
    vecs.push_back(mk(STR, A_NONE, 32'h40, W, 1'b0, 32'h55555555, 32'h0,        0, 1'b0, 1));
    vecs.push_back(mk(NO,  A_SC,   32'h40, W, 1'b0, 32'h99999999, 32'h1,        1, 1'b0, 1));
    vecs.push_back(mk(LD,  A_NONE, 32'h40, W, 1'b0, 32'h0,        32'h55555555, 1, 1'b0, 1));
    vecs.push_back(mk(LD,  A_NONE, 32'h21, H, 1'b0, 32'h0,        32'h0,        1, 1'b1, 1));
    vecs.push_back(mk(NO,  A_ADD,  32'h22, W, 1'b0, 32'h7,        32'h0,        1, 1'b1, 1));
    vecs.push_back(mk(LD,  A_NONE, 32'h20, W, 1'b0, 32'h0,        32'h3,        1, 1'b0, 1));
    vecs.push_back(mk(STR, A_NONE, 32'h21, B, 1'b0, 32'h000000A5, 32'h0,        0, 1'b0, 1));
    vecs.push_back(mk(LD,  A_NONE, 32'h20, W, 1'b0, 32'h0,        32'h0000A503, 1, 1'b0, 1));
    vecs.push_back(mk(STR, A_NONE, 32'h22, H, 1'b0, 32'h00001234, 32'h0,        0, 1'b0, 1));
    vecs.push_back(mk(LD,  A_NONE, 32'h20, W, 1'b0, 32'h0,        32'h1234A503, 1, 1'b0, 1));
    vecs.push_back(mk(NO,  A_SWAP12, 32'h20, W, 1'b0, 32'h77,     32'h1234A503, 1, 1'b0, 2));
    vecs.push_back(mk(LD,  A_NONE, 32'h20, W, 1'b0, 32'h0,        32'h00000077, 1, 1'b0, 1));
    vecs.push_back(mk(LD,  A_NONE, 32'h4020, W, 1'b0, 32'h0,      32'h00000077, 1, 1'b0, 1));

    foreach (vecs[i]) begin
      v = model(vecs[i]);
      run(vecs[i], $sformatf("vec%0d", i));
    end

    // Reserved control code 11 is not a request.
    @(negedge CLK);
    DATA_CACHE_CONTROL = 2'b11;
    @(negedge CLK);
    chk("ctrl11 CACHE_READY", {31'h0, CACHE_READY}, 32'h1);
    chk("ctrl11 RDATA_VALID", {31'h0, RDATA_VALID}, 32'h0);
    drive_idle();

    // A store held while the responder is busy with an AMO must be ignored.
    v = mk(NO, A_ADD, 32'h20, W, 1'b0, 32'h1, 32'h0, 0, 1'b0, 0);
    v = model(v);
    @(negedge CLK);
    drive(v);
    @(posedge CLK);
    #1 drive(mk(STR, A_NONE, 32'h20, W, 1'b0, 32'hBAD0BAD0, 32'h0, 0, 1'b0, 0));
    @(negedge CLK);
    chk("busy AMO_RD CACHE_READY", {31'h0, CACHE_READY}, 32'h0);
    @(negedge CLK);
    chk("busy AMO_WR CACHE_READY", {31'h0, CACHE_READY}, 32'h0);
    chk("busy AMO_WR RDATA_VALID", {31'h0, RDATA_VALID}, 32'h1);
    chk("busy AMO_WR RDATA", RDATA, v.exp_rdata);
    drive_idle();
    run(model(mk(LD, A_NONE, 32'h20, W, 1'b0, 32'h0, 32'h0, 0, 1'b0, 0)), "after_busy_load");

    // Reset in the middle of an AMO aborts it before the write.
    run(model(mk(STR, A_NONE, 32'h60, W, 1'b0, 32'hABCD0000, 32'h0, 0, 1'b0, 0)), "pre_rst_store");
    drive(mk(NO, A_ADD, 32'h60, W, 1'b0, 32'h1, 32'h0, 0, 1'b0, 0));
    @(posedge CLK);
    #1 drive_idle();
    #1 RST_N = 1'b0;
    #1;
    chk("midamo_rst CACHE_READY", {31'h0, CACHE_READY}, 32'h1);
    chk("midamo_rst RDATA_VALID", {31'h0, RDATA_VALID}, 32'h0);
    chk("midamo_rst RDATA", RDATA, 32'h0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    m_rv = 1'b0;
    run(model(mk(LD, A_NONE, 32'h60, W, 1'b0, 32'h0, 32'h0, 0, 1'b0, 0)), "post_rst_load");

    // Randomized phase over a 16-word window, with aliasing via high address bits.
    for (int w = 0; w < 16; w++) begin
      v = mk(STR, A_NONE, 32'h100 + 32'(4 * w), W, 1'b0, $urandom, 32'h0, 0, 1'b0, 0);
      run(model(v), $sformatf("init%0d", w));
    end
    for (int i = 0; i < 300; i++) begin
      v = mk(NO, A_NONE, 32'h100 + 32'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, 32'h0, 0, 1'b0, 0);
      if ($urandom_range(0, 3) == 0) v.addr = v.addr | (32'($urandom_range(1, 3)) << 14);
      k = $urandom_range(0, 9);
      if (k < 4) v.ctrl = LD;
      else if (k < 7) v.ctrl = STR;
      else begin
        v.ctrl = 2'($urandom_range(0, 3));
        v.amo = {1'b1, 4'($urandom_range(0, 15))};
        if ($urandom_range(0, 2) == 0) v.amo[3:0] = 4'($urandom_range(0, 1));
        if ($urandom_range(0, 3) != 0) v.addr[1:0] = 2'b00;
      end
      run(model(v), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
